// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the hazard/stall controller and its multiply counter.
package hazard_stall_controller_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_e;

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // The youngest producer (EX) wins over the older one (MEM).
    function automatic logic [1:0] fwd_sel(logic ex_hit, logic mem_hit);
        if (ex_hit) begin
            return FWD_MEM;
        end else if (mem_hit) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_mul_wait_counter.sv
// Down-counter tracking the remaining EX hold cycles of a multi-cycle multiply.
module mul_wait_counter
    import hazard_stall_controller_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush/bubble sequencing plus multiply hold for the 5-stage datapath.
// Define HAZARD_FORWARDING_EN to enable registered ALU operand forwarding selects.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned REG_ADDR_W  = 5
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UsesRt,
    input  logic [REG_ADDR_W-1:0] EX_Rd,
    input  logic                  EX_RegWrite,
    input  logic                  EX_MemRead,
    input  logic                  EX_IsMul,
    input  logic [REG_ADDR_W-1:0] MEM_Rd,
    input  logic                  MEM_RegWrite,
    input  logic                  PCSrc,
    output logic                  PCWrite,
    output logic                  IFID_Write,
    output logic                  IFID_Flush,
    output logic                  IDEX_Bubble,
    output logic                  EX_Hold,
    output logic                  MulDone,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB
);

    localparam bit MulMulti = (MUL_LATENCY > 1);
    // The RUN cycle is the first hold cycle, so MUL_WAIT starts counting from latency-2.
    localparam logic [CNT_W-1:0] MulLoad = MulMulti ? CNT_W'(MUL_LATENCY - 2) : '0;

    function automatic logic src_match(logic [REG_ADDR_W-1:0] src, logic [REG_ADDR_W-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    logic a_ex, b_ex, a_mem, b_mem;
    logic data_hazard;

    assign a_ex  = src_match(ID_Rs, EX_Rd);
    assign b_ex  = ID_UsesRt && src_match(ID_Rt, EX_Rd);
    assign a_mem = src_match(ID_Rs, MEM_Rd);
    assign b_mem = ID_UsesRt && src_match(ID_Rt, MEM_Rd);

`ifdef HAZARD_FORWARDING_EN
    assign data_hazard = EX_MemRead && EX_RegWrite && (a_ex || b_ex);
`else
    logic unused_ex_mem_read;
    assign unused_ex_mem_read = EX_MemRead;
    // No forwarding: wait until the producer reaches WB (write-first register file).
    assign data_hazard = (EX_RegWrite && (a_ex || b_ex)) || (MEM_RegWrite && (a_mem || b_mem));
`endif

    state_e state_q, state_d;
    logic   cnt_load, cnt_dec, cnt_done;
    logic   pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, mul_done;

    mul_wait_counter u_mul_wait_counter (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .load_i     (cnt_load),
        .load_val_i (MulLoad),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d     = state_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        mul_done    = 1'b0;
        // Reset forces the free-running outputs even though the inputs may still request a hold.
        if (!Rst) begin
            unique case (state_q)
                RUN: begin
                    if (PCSrc) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (EX_IsMul && MulMulti) begin
                        ex_hold    = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        cnt_load   = 1'b1;
                        state_d    = MUL_WAIT;
                    end else if (EX_IsMul) begin
                        mul_done = 1'b1;
                    end else if (data_hazard) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    if (!cnt_done) begin
                        ex_hold    = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        cnt_dec    = 1'b1;
                    end else begin
                        mul_done = 1'b1;
                        state_d  = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign PCWrite     = pc_write;
    assign IFID_Write  = ifid_write;
    assign IFID_Flush  = ifid_flush;
    assign IDEX_Bubble = idex_bubble;
    assign EX_Hold     = ex_hold;
    assign MulDone     = mul_done;

`ifdef HAZARD_FORWARDING_EN
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    // Selects follow the instruction into EX: cleared for a bubble, frozen while EX holds.
    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (idex_bubble) begin
            fwd_a_d = FWD_REG;
            fwd_b_d = FWD_REG;
        end else if (!ex_hold) begin
            fwd_a_d = fwd_sel(EX_RegWrite && a_ex, MEM_RegWrite && a_mem);
            fwd_b_d = fwd_sel(EX_RegWrite && b_ex, MEM_RegWrite && b_mem);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign ForwardA = fwd_a_q;
    assign ForwardB = fwd_b_q;
`else
    assign ForwardA = FWD_REG;
    assign ForwardB = FWD_REG;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller (MUL_LATENCY=4); expectations adapt to
// HAZARD_FORWARDING_EN.
module tb_hazard_stall_controller;

`ifdef HAZARD_FORWARDING_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] exrd;
        logic       exrw;
        logic       exmr;
        logic       exmul;
        logic [4:0] memrd;
        logic       memrw;
        logic       pcsrc;
    } in_t;

    // ctrl = {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EX_Hold, MulDone}
    typedef struct packed {
        logic [5:0] ctrl;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    logic       Clk, Rst;
    logic [4:0] ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
    logic       ID_UsesRt, EX_RegWrite, EX_MemRead, EX_IsMul, MEM_RegWrite, PCSrc;
    logic       PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EX_Hold, MulDone;
    logic [1:0] ForwardA, ForwardB;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    hazard_stall_controller #(
        .MUL_LATENCY (4),
        .REG_ADDR_W  (5)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_UsesRt    (ID_UsesRt),
        .EX_Rd        (EX_Rd),
        .EX_RegWrite  (EX_RegWrite),
        .EX_MemRead   (EX_MemRead),
        .EX_IsMul     (EX_IsMul),
        .MEM_Rd       (MEM_Rd),
        .MEM_RegWrite (MEM_RegWrite),
        .PCSrc        (PCSrc),
        .PCWrite      (PCWrite),
        .IFID_Write   (IFID_Write),
        .IFID_Flush   (IFID_Flush),
        .IDEX_Bubble  (IDEX_Bubble),
        .EX_Hold      (EX_Hold),
        .MulDone      (MulDone),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic in_t mk_in(logic [4:0] rs, logic [4:0] rt, logic urt, logic [4:0] exrd,
                                  logic exrw, logic exmr, logic exmul, logic [4:0] memrd,
                                  logic memrw, logic pcsrc);
        in_t v;
        v = '{rs: rs, rt: rt, urt: urt, exrd: exrd, exrw: exrw, exmr: exmr, exmul: exmul,
              memrd: memrd, memrw: memrw, pcsrc: pcsrc};
        return v;
    endfunction

    function automatic exp_t mk_exp(logic [5:0] ctrl, logic [1:0] fa, logic [1:0] fb);
        exp_t e;
        e = '{ctrl: ctrl, fa: fa, fb: fb};
        return e;
    endfunction

    task automatic apply(input in_t v);
        ID_Rs        = v.rs;
        ID_Rt        = v.rt;
        ID_UsesRt    = v.urt;
        EX_Rd        = v.exrd;
        EX_RegWrite  = v.exrw;
        EX_MemRead   = v.exmr;
        EX_IsMul     = v.exmul;
        MEM_Rd       = v.memrd;
        MEM_RegWrite = v.memrw;
        PCSrc        = v.pcsrc;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_value({tag, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            e = sb_q.pop_front();
            check_value({tag, "_ctrl"},
                        {2'b00, PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EX_Hold, MulDone},
                        {2'b00, e.ctrl});
            check_value({tag, "_fwd"}, {4'b0000, ForwardA, ForwardB}, {4'b0000, e.fa, e.fb});
        end
    endtask

    // Called 1 time unit after a rising edge; samples mid-cycle at the falling edge.
    task automatic drive_check(input string tag, input in_t v, input exp_t e);
        apply(v);
        sb_q.push_back(e);
        #4;
        compare_out(tag);
    endtask

    task automatic step(input string tag, input in_t v, input exp_t e);
        drive_check(tag, v, e);
        @(posedge Clk);
        #1;
    endtask

    localparam logic [5:0] C_RUN   = 6'b110000;
    localparam logic [5:0] C_STALL = 6'b000100;
    localparam logic [5:0] C_BR    = 6'b111100;
    localparam logic [5:0] C_HOLD  = 6'b000010;
    localparam logic [5:0] C_DONE  = 6'b110001;

    in_t idle, mul_i;

    initial begin
        idle  = mk_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        mul_i = mk_in(5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);

        // Reset held with a multiply presented: outputs must stay free-running.
        Rst = 1'b1;
        apply(mul_i);
        sb_q.push_back(mk_exp(C_RUN, 2'b00, 2'b00));
        #3;
        compare_out("reset_mul");
        @(negedge Clk);
        Rst = 1'b0;
        apply(idle);
        @(posedge Clk);
        #1;

        step("idle", idle, mk_exp(C_RUN, 2'b00, 2'b00));
        step("load_use", mk_in(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0),
             mk_exp(C_STALL, 2'b00, 2'b00));
        step("prod_in_mem", mk_in(5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0),
             mk_exp(Fwd ? C_RUN : C_STALL, 2'b00, 2'b00));
        step("prod_in_wb", mk_in(5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0),
             mk_exp(C_RUN, Fwd ? 2'b01 : 2'b00, 2'b00));
        step("load_r0", mk_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0),
             mk_exp(C_RUN, 2'b00, 2'b00));
        step("branch_prio", mk_in(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1),
             mk_exp(C_BR, 2'b00, 2'b00));
        step("fwd_ex_mem", mk_in(5'd5, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0),
             mk_exp(Fwd ? C_RUN : C_STALL, 2'b00, 2'b00));

        // Multiply: three hold cycles then the done pulse; forwards must stay frozen.
        step("mul1_h0", mul_i, mk_exp(C_HOLD, Fwd ? 2'b10 : 2'b00, 2'b00));
        step("mul1_h1", mul_i, mk_exp(C_HOLD, Fwd ? 2'b10 : 2'b00, 2'b00));
        step("mul1_h2_br", mk_in(5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1),
             mk_exp(C_HOLD, Fwd ? 2'b10 : 2'b00, 2'b00));
        step("mul1_done", mul_i, mk_exp(C_DONE, Fwd ? 2'b10 : 2'b00, 2'b00));
        step("mul2_h0", mul_i, mk_exp(C_HOLD, 2'b00, 2'b00));
        step("mul2_h1", mul_i, mk_exp(C_HOLD, 2'b00, 2'b00));
        drive_check("mul2_h2", mul_i, mk_exp(C_HOLD, 2'b00, 2'b00));

        // Reset in the middle of the hold drops it immediately.
        #2;
        Rst = 1'b1;
        sb_q.push_back(mk_exp(C_RUN, 2'b00, 2'b00));
        #1;
        compare_out("reset_mid_mul");
        @(posedge Clk);
        #1;
        Rst = 1'b0;

        step("mul3_h0", mul_i, mk_exp(C_HOLD, 2'b00, 2'b00));
        step("mul3_h1", mul_i, mk_exp(C_HOLD, 2'b00, 2'b00));
        step("mul3_h2", mul_i, mk_exp(C_HOLD, 2'b00, 2'b00));
        step("mul3_done", mul_i, mk_exp(C_DONE, 2'b00, 2'b00));
        step("idle_end", idle, mk_exp(C_RUN, 2'b00, 2'b00));

        check_value("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing block for the 5-stage datapath. It sits beside Controller, ALUControl, ALU32Bit and Branch.
- Generates the PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush.
- Holds the EX stage while a multi-cycle multiply occupies ALU32Bit.
- Under a macro, also produces registered operand-forwarding selects for the ALU inputs.

Parameters:
MUL_LATENCY, 4, total EX-stage cycles a multiply occupies the ALU (legal range 1..16)
REG_ADDR_W, 5, register specifier width

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-high reset
ID_Rs  in  REG_ADDR_W  source register A of instruction in ID
ID_Rt  in  REG_ADDR_W  source register B of instruction in ID
ID_UsesRt  in  1  ID instruction reads Rt (R-type, store, branch)
EX_Rd  in  REG_ADDR_W  destination of instruction in EX
EX_RegWrite  in  1  EX instruction writes a register
EX_MemRead  in  1  EX instruction is a load
EX_IsMul  in  1  EX instruction is a multiply
MEM_Rd  in  REG_ADDR_W  destination of instruction in MEM
MEM_RegWrite  in  1  MEM instruction writes a register
PCSrc  in  1  taken branch resolved in EX (from Branch)
PCWrite  out  1  PC update enable
IFID_Write  out  1  IF/ID register enable
IFID_Flush  out  1  clear IF/ID to NOP
IDEX_Bubble  out  1  load NOP control into ID/EX
EX_Hold  out  1  freeze ID/EX and EX/MEM, keep ALU inputs stable
MulDone  out  1  one-cycle pulse, multiply result valid this cycle
ForwardA  out  2  registered ALU operand A select (00 regfile, 01 WB, 10 MEM)
ForwardB  out  2  registered ALU operand B select

Behaviour:
- Clocking and reset:
  - Clk is the only clock. Rst is asynchronous and active-high.
  - Reset values: state=RUN, cnt=0, ForwardA=ForwardB=00.
  - Combinational outputs during reset: PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0, EX_Hold=0, MulDone=0.
- Output timing:
  - Control outputs are combinational from the registered state and the current inputs.
  - ForwardA/B are registered.
- Match definition: srcA = (ID_Rs!=0 && ID_Rs==X). srcB uses ID_Rt, gated by ID_UsesRt. Register 0 never matches.
- FSM states: RUN, MUL_WAIT. cnt is 4 bits.
- RUN, priority order (first match wins):
  1. PCSrc=1: IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, IFID_Write=1. Any stall condition is ignored.
  2. EX_IsMul=1 and MUL_LATENCY>1: EX_Hold=1, PCWrite=0, IFID_Write=0, IDEX_Bubble=0. Next state MUL_WAIT, cnt<=MUL_LATENCY-2.
  3. EX_IsMul=1 and MUL_LATENCY=1: MulDone=1, no hold. Stay in RUN.
  4. Data hazard (defined under Optional Feature): PCWrite=0, IFID_Write=0, IDEX_Bubble=1.
  5. Otherwise: free run.
- MUL_WAIT:
  - cnt!=0: EX_Hold=1, PCWrite=0, IFID_Write=0. cnt decrements.
  - cnt==0: EX_Hold=0, MulDone=1. Next state RUN; the pipeline advances at this edge.
  - PCSrc and data hazards are ignored. The multiply owns EX, so no branch can resolve.
- Multiply timing:
  - Total EX occupancy is MUL_LATENCY cycles, of which MUL_LATENCY-1 are hold cycles.
  - Back-to-back multiplies restart from RUN with no idle cycle.
- Reset mid-multiply: state returns to RUN immediately; the hold drops asynchronously.
- Forward registers:
  - Update only on an edge where the pipeline advances into EX (EX_Hold=0 and IDEX_Bubble=0). They hold while EX_Hold=1.
  - Cleared to 00 on an edge where IDEX_Bubble=1.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined:
  - Data hazard = EX_MemRead && EX_RegWrite && (srcA(EX_Rd) || srcB(EX_Rd)). This is a single-cycle load-use stall.
  - ForwardA next value = 10 if EX_RegWrite && srcA(EX_Rd); else 01 if MEM_RegWrite && srcA(MEM_Rd); else 00. EX takes priority over MEM.
  - ForwardB is computed the same way from srcB.
- Undefined:
  - Data hazard = (EX_RegWrite && (srcA(EX_Rd) || srcB(EX_Rd))) || (MEM_RegWrite && (srcA(MEM_Rd) || srcB(MEM_Rd))). The stall repeats until the producer reaches WB; the register file is write-first.
  - ForwardA/B tied to 00 and the forward registers are not generated.

Decomposition:
- Shared package: state enum {RUN, MUL_WAIT}; forward-select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One natural sub-module: mul_wait_counter. It holds cnt and the load/decrement logic and outputs a done flag when cnt==0.

Test Plan:
- Reset: assert Rst mid-cycle with EX_IsMul=1 -> all outputs at reset values immediately, state RUN.
- Load-use: EX_MemRead=1, EX_RegWrite=1, EX_Rd=8, ID_Rs=8 -> one cycle PCWrite=0, IFID_Write=0, IDEX_Bubble=1. With the macro, EX_Rd=0 -> no stall.
- Branch priority: PCSrc=1 together with a load-use match -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1; no stall.
- Multiply with MUL_LATENCY=4: EX_IsMul=1 -> EX_Hold=1 for 3 cycles, then MulDone=1 with EX_Hold=0. A second multiply immediately after -> 3 more hold cycles.
- Forwarding (macro defined): EX_Rd=5/EX_RegWrite=1, MEM_Rd=5/MEM_RegWrite=1, ID_Rs=5 -> ForwardA=10 after the advancing edge. With ID_Rt=5 and ID_UsesRt=0 -> ForwardB=00. ForwardA is held unchanged across EX_Hold cycles.
- No macro: ID_Rs matches MEM_Rd -> exactly one stall cycle; ForwardA/B always 00.
